// File: rtl/seq_divider.sv
// Sequential signed divider: 64-bit dividend / 32-bit divisor, radix-2 restoring,
// one quotient bit per clock, valid/ready handshakes on both sides.
module seq_divider #(
  parameter int unsigned DW = 64,
  parameter int unsigned VW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero,
  output logic          overflow
);

  localparam int unsigned CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dq;        // dividend bits shift out of the top, quotient bits shift in
  logic [VW-1:0] rem;
  logic [VW:0]   dvs_abs;
  logic          sign_q;
  logic          sign_r;
  logic          zero_div;
  logic          ovf_pend;
  logic [VW-1:0] raw_lo;
  logic [CW-1:0] count;

  logic [VW:0]   shifted;
  logic [VW:0]   diff;
  logic          qbit;
  logic [VW-1:0] rem_next;
  logic [DW-1:0] dq_next;
  logic [DW-1:0] dividend_abs;
  logic [VW:0]   divisor_abs;

  always_comb begin
    shifted      = {rem, dq[DW-1]};
    // partial remainder < 2*|divisor| <= 2^32, so bit VW of the difference is its sign
    diff         = shifted - dvs_abs;
    qbit         = ~diff[VW];
    rem_next     = qbit ? diff[VW-1:0] : shifted[VW-1:0];
    dq_next      = {dq[DW-2:0], qbit};
    dividend_abs = dividend[DW-1] ? -dividend : dividend;
    divisor_abs  = divisor[VW-1] ? -{divisor[VW-1], divisor} : {1'b0, divisor};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      dq          <= '0;
      rem         <= '0;
      dvs_abs     <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      zero_div    <= 1'b0;
      ovf_pend    <= 1'b0;
      raw_lo      <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            dq       <= dividend_abs;
            rem      <= '0;
            dvs_abs  <= divisor_abs;
            sign_q   <= dividend[DW-1] ^ divisor[VW-1];
            sign_r   <= dividend[DW-1];
            zero_div <= (divisor == '0);
            ovf_pend <= (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
            raw_lo   <= dividend[VW-1:0];
            count    <= '0;
            state    <= CALC;
          end
        end
        CALC: begin
          // divide-by-zero takes one pass through CALC so its result appears one edge after acceptance
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= raw_lo;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            out_valid   <= 1'b1;
            state       <= DONE;
          end else begin
            rem   <= rem_next;
            dq    <= dq_next;
            count <= count + 1'b1;
            if (count == CW'(DW - 1)) begin
              quotient    <= sign_q ? -dq_next : dq_next;
              remainder   <= sign_r ? -rem_next : rem_next;
              div_by_zero <= 1'b0;
              overflow    <= ovf_pend;
              out_valid   <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: expected results queued at issue, compared at out_valid.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  typedef struct packed {
    logic [63:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  seq_divider #(.DW(64), .VW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic signed [63:0] a, input logic signed [31:0] b);
    exp_t   e;
    longint bl;
    e = '0;
    if (b == 0) begin
      e.q = '1;
      e.r = a[31:0];
      e.dbz = 1'b1;
    end else if (a == 64'sh8000_0000_0000_0000 && b == -32'sd1) begin
      e.q = 64'h8000_0000_0000_0000;
      e.r = '0;
      e.ovf = 1'b1;
    end else begin
      bl = longint'(b);
      e.q = a / bl;
      e.r = 32'(a % bl);
    end
    return e;
  endfunction

  task automatic issue(input logic [63:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(negedge clk);
    in_valid = 1'b0;
    dividend = {$urandom, $urandom};
    divisor  = $urandom;
  endtask

  task automatic collect(input int exp_lat, input int stall);
    int   lat = 0;
    exp_t e;
    if (stall > 0) out_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("sb_size", 64'(sb.size()), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check("quotient", quotient, e.q);
    check("remainder", {32'd0, remainder}, {32'd0, e.r});
    check("div_by_zero", {63'd0, div_by_zero}, {63'd0, e.dbz});
    check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
    check("busy_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      dividend = 64'd9;
      divisor  = 32'd3;
      @(negedge clk);
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_quotient", quotient, e.q);
      check("stall_remainder", {32'd0, remainder}, {32'd0, e.r});
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("xfer_valid_low", {63'd0, out_valid}, 64'd0);
    check("xfer_in_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    logic [31:0] b;

    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", {32'd0, remainder}, 64'd0);
    check("rst_flags", {62'd0, div_by_zero, overflow}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    issue(64'd838102050, 32'd67890);        collect(64, 0);
    issue(-64'sd121919220, 32'd12345);      collect(64, 0);
    issue(-64'sd7, 32'd2);                  collect(64, 0);
    issue(64'd7, -32'sd2);                  collect(64, 5);
    issue(64'd100, 32'd0);                  collect(1, 0);
    issue(64'h8000_0000_0000_0000, '1);     collect(64, 0);
    issue(64'h8000_0000_0000_0000, 32'h8000_0000); collect(64, 0);
    issue(64'h7FFF_FFFF_FFFF_FFFF, 32'd1);  collect(64, 0);
    issue(-64'sd5, 32'd0);                  collect(1, 0);

    for (int i = 0; i < 6; i++) begin
      a = {$urandom, $urandom};
      b = (i < 3) ? $urandom : 32'($urandom_range(1, 1000));
      if (b == 0) b = 32'd1;
      if (i[0]) b = -b;
      issue(a, b);
      collect(64, 0);
    end

    issue(64'd12345, 32'd7);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_quotient", quotient, 64'd0);
    check("mid_rst_remainder", {32'd0, remainder}, 64'd0);
    check("mid_rst_flags", {62'd0, div_by_zero, overflow}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
    if (sb.size() > 0) void'(sb.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_release_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_no_result", {63'd0, out_valid}, 64'd0);
    issue(64'd6, 32'd3);                    collect(64, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
